// File: rtl/fifo_ast_reader.sv
// Read-clock-domain bridge from the video FIFO read port to an Avalon-ST video source.
// Adds the packet-type header beat, drops out-of-packet words and repairs truncated packets.
module fifo_ast_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_TYPE   = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n_in,
  input  logic                  Clear_in,
  input  logic [DATA_WIDTH+1:0] Fifo_data_in,
  input  logic                  Fifo_empty_in,
  output logic                  Fifo_read_en_out,
  output logic [DATA_WIDTH-1:0] Ast_data_out,
  output logic                  Ast_valid_out,
  input  logic                  Ast_ready_in,
  output logic                  Ast_sop_out,
  output logic                  Ast_eop_out,
  output logic [15:0]           Drop_count_out,
  output logic                  Trunc_out
);

  localparam int WW = DATA_WIDTH + 2;
  localparam logic [3:0] PKT_NIB = PKT_TYPE[3:0];
  localparam logic [DATA_WIDTH-1:0] HDR_WORD = {{(DATA_WIDTH-4){1'b0}}, PKT_NIB};

  typedef enum logic [1:0] {IDLE, HDR, FIRST, DATA} state_t;

  state_t                state_q, state_d;
  logic [WW-1:0]         buf_q [2];
  logic [WW-1:0]         buf_d [2];
  logic [1:0]            buf_occ_q, buf_occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] ast_data_q, ast_data_d;
  logic                  ast_valid_q, ast_valid_d;
  logic                  ast_sop_q, ast_sop_d;
  logic                  ast_eop_q, ast_eop_d;
  logic                  trunc_q, trunc_d;
  logic [15:0]           drop_q, drop_d;

  logic                  read_en;
  logic                  head_valid, head_sop, head_eop;
  logic [DATA_WIDTH-1:0] head_pix;
  logic [WW-1:0]         head;
  logic                  slot_free, pop, take_bypass;
  logic [1:0]            occ_mid;

  assign read_en = !Fifo_empty_in && !Clear_in &&
                   (({1'b0, buf_occ_q} + {2'b00, inflight_q}) < 3'd2);

  // An empty buffer lets the word arriving from the FIFO act as head directly.
  assign head_valid = (buf_occ_q != 2'd0) || inflight_q;
  assign head       = (buf_occ_q != 2'd0) ? buf_q[0] : Fifo_data_in;
  assign head_sop   = head[WW-1];
  assign head_eop   = head[WW-2];
  assign head_pix   = head[DATA_WIDTH-1:0];
  assign slot_free  = !ast_valid_q || Ast_ready_in;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    ast_data_d  = ast_data_q;
    ast_sop_d   = ast_sop_q;
    ast_eop_d   = ast_eop_q;
    ast_valid_d = ast_valid_q && !Ast_ready_in;
    trunc_d     = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        if (head_valid) begin
          if (!head_sop) begin
            pop = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (head_valid && slot_free) begin
          ast_data_d  = HDR_WORD;
          ast_sop_d   = 1'b1;
          ast_eop_d   = 1'b0;
          ast_valid_d = 1'b1;
          state_d     = FIRST;
        end
      end
      FIRST: begin
        if (head_valid && slot_free) begin
          ast_data_d  = head_pix;
          ast_sop_d   = 1'b0;
          ast_eop_d   = head_eop;
          ast_valid_d = 1'b1;
          pop         = 1'b1;
          state_d     = head_eop ? IDLE : DATA;
        end
      end
      DATA: begin
        if (head_valid && slot_free) begin
          ast_sop_d   = 1'b0;
          ast_valid_d = 1'b1;
          if (!head_sop) begin
            ast_data_d = head_pix;
            ast_eop_d  = head_eop;
            pop        = 1'b1;
            if (head_eop) state_d = IDLE;
          end else begin
            // Premature SOP: close this packet with a filler and keep the SOP word.
            ast_data_d = '0;
            ast_eop_d  = 1'b1;
            trunc_d    = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d       = buf_q;
    occ_mid     = buf_occ_q;
    take_bypass = pop && (buf_occ_q == 2'd0);
    if (pop && (buf_occ_q != 2'd0)) begin
      buf_d[0] = buf_q[1];
      occ_mid  = buf_occ_q - 2'd1;
    end
    buf_occ_d = occ_mid;
    if (inflight_q && !take_bypass && (occ_mid < 2'd2)) begin
      buf_d[occ_mid[0]] = Fifo_data_in;
      buf_occ_d         = occ_mid + 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      state_q     <= IDLE;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      buf_occ_q   <= '0;
      inflight_q  <= 1'b0;
      ast_data_q  <= '0;
      ast_valid_q <= 1'b0;
      ast_sop_q   <= 1'b0;
      ast_eop_q   <= 1'b0;
      trunc_q     <= 1'b0;
      drop_q      <= '0;
    end else if (Clear_in) begin
      state_q     <= IDLE;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      buf_occ_q   <= '0;
      inflight_q  <= 1'b0;
      ast_data_q  <= '0;
      ast_valid_q <= 1'b0;
      ast_sop_q   <= 1'b0;
      ast_eop_q   <= 1'b0;
      trunc_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_occ_q   <= buf_occ_d;
      inflight_q  <= read_en;
      ast_data_q  <= ast_data_d;
      ast_valid_q <= ast_valid_d;
      ast_sop_q   <= ast_sop_d;
      ast_eop_q   <= ast_eop_d;
      trunc_q     <= trunc_d;
      drop_q      <= drop_d;
    end
  end

  assign Fifo_read_en_out = read_en;
  assign Ast_data_out     = ast_data_q;
  assign Ast_valid_out    = ast_valid_q;
  assign Ast_sop_out      = ast_sop_q;
  assign Ast_eop_out      = ast_eop_q;
  assign Drop_count_out   = drop_q;
  assign Trunc_out        = trunc_q;

endmodule
